// File: rtl/tag_trap_sequencer.sv
// Tag trap sequencer.
//
// Registers the tag-compare PLA result (ptagcompare) for operations that ask for a
// tag check, stalls the operand stage while it evaluates, and on a failed check
// raises a held trap request carrying the trapping PC and tags. A saturating
// counter records the number of traps taken.
//
// Optional feature, enabled by defining TAG_TRAP_MASK_EN:
//   adds input trap_enable. A failed check evaluated with trap_enable=0 is still
//   counted and still loads trap_pc/trap_tags, but returns straight to idle
//   without raising trap_req.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op_valid, op_ready    operand-stage handshake; op_ready decodes the idle state
//   op_tag_check          operation requests a tag check
//   ptagcompare           PLA result, 1 = tags acceptable
//   tag_a, tag_b, op_pc   busA[31:28], busB[31:28] and PC of the current operation
//   trap_enable           (TAG_TRAP_MASK_EN only) allow a failed check to trap
//   check_pass            one-cycle pulse while a passing check is evaluated
//   trap_req, trap_ack    held trap request and its acknowledge
//   trap_pc, trap_tags    PC and {tag_a, tag_b} of the most recent failed check
//   trap_count            saturating count of failed checks
//   busy                  sequencer is not idle
module tag_trap_sequencer #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic             op_tag_check,
  input  logic             ptagcompare,
  input  logic [3:0]       tag_a,
  input  logic [3:0]       tag_b,
  input  logic [PC_W-1:0]  op_pc,
`ifdef TAG_TRAP_MASK_EN
  input  logic             trap_enable,
`endif
  output logic             op_ready,
  output logic             check_pass,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic [PC_W-1:0]  trap_pc,
  output logic [7:0]       trap_tags,
  output logic [CNT_W-1:0] trap_count,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StEval, StTrap, StRecover} state_e;

  state_e          state_q;
  logic            cmp_q;
  logic [3:0]      tag_a_q;
  logic [3:0]      tag_b_q;
  logic [PC_W-1:0] pc_q;
  logic            trap_en;
  logic            accept;

`ifdef TAG_TRAP_MASK_EN
  assign trap_en = trap_enable;
`else
  assign trap_en = 1'b1;
`endif

  assign op_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign accept   = op_valid & op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmp_q      <= 1'b0;
      tag_a_q    <= 4'h0;
      tag_b_q    <= 4'h0;
      pc_q       <= '0;
      check_pass <= 1'b0;
      trap_req   <= 1'b0;
      trap_pc    <= '0;
      trap_tags  <= 8'h00;
      trap_count <= '0;
    end else begin
      check_pass <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Untagged operations flow through without leaving idle.
          if (accept && op_tag_check) begin
            cmp_q      <= ptagcompare;
            tag_a_q    <= tag_a;
            tag_b_q    <= tag_b;
            pc_q       <= op_pc;
            // Pulse is registered here so it is visible throughout the eval cycle.
            check_pass <= ptagcompare;
            state_q    <= StEval;
          end
        end
        StEval: begin
          if (cmp_q) begin
            state_q <= StIdle;
          end else begin
            trap_pc   <= pc_q;
            trap_tags <= {tag_a_q, tag_b_q};
            if (trap_count != '1) begin
              trap_count <= trap_count + CNT_W'(1);
            end
            if (trap_en) begin
              trap_req <= 1'b1;
              state_q  <= StTrap;
            end else begin
              state_q  <= StIdle;
            end
          end
        end
        StTrap: begin
          if (trap_ack) begin
            trap_req <= 1'b0;
            state_q  <= StRecover;
          end
        end
        StRecover: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_trap_sequencer.sv
module tb_tag_trap_sequencer;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic             op_tag_check;
  logic             ptagcompare;
  logic [3:0]       tag_a;
  logic [3:0]       tag_b;
  logic [PC_W-1:0]  op_pc;
  logic             trap_enable;
  logic             op_ready;
  logic             check_pass;
  logic             trap_req;
  logic             trap_ack;
  logic [PC_W-1:0]  trap_pc;
  logic [7:0]       trap_tags;
  logic [CNT_W-1:0] trap_count;
  logic             busy;

  int n_cmp;
  int n_err;

  tag_trap_sequencer #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_tag_check (op_tag_check),
    .ptagcompare  (ptagcompare),
    .tag_a        (tag_a),
    .tag_b        (tag_b),
    .op_pc        (op_pc),
`ifdef TAG_TRAP_MASK_EN
    .trap_enable  (trap_enable),
`endif
    .op_ready     (op_ready),
    .check_pass   (check_pass),
    .trap_req     (trap_req),
    .trap_ack     (trap_ack),
    .trap_pc      (trap_pc),
    .trap_tags    (trap_tags),
    .trap_count   (trap_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accepting edge, then withdraw it.
  task automatic issue(input logic chk, input logic cmp, input logic [3:0] ta,
                       input logic [3:0] tb, input logic [PC_W-1:0] pc);
    op_valid     = 1'b1;
    op_tag_check = chk;
    ptagcompare  = cmp;
    tag_a        = ta;
    tag_b        = tb;
    op_pc        = pc;
    step();
    op_valid     = 1'b0;
    op_tag_check = 1'b0;
    ptagcompare  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_op_ready got=%b want=1", op_ready);
    end
    n_cmp++;
    if (trap_req !== 1'b0) begin
      n_err++; $display("FAIL reset_trap_req got=%b want=0", trap_req);
    end
    n_cmp++;
    if (trap_count !== 2'd0) begin
      n_err++; $display("FAIL reset_trap_count got=%0d want=0", trap_count);
    end
    n_cmp++;
    if (busy !== 1'b0 || check_pass !== 1'b0) begin
      n_err++; $display("FAIL reset_busy_pass got=%b%b want=00", busy, check_pass);
    end
    n_cmp++;
    if (trap_pc !== 32'h0 || trap_tags !== 8'h00) begin
      n_err++; $display("FAIL reset_trap_info got=%h/%h want=0/0", trap_pc, trap_tags);
    end
  endtask

  task automatic test_pass();
    issue(1'b1, 1'b1, 4'h0, 4'h0, 32'h0000_0100);
    n_cmp++;
    if (check_pass !== 1'b1 || op_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pass_eval got pass/ready/busy=%b%b%b want=101", check_pass, op_ready, busy);
    end
    // Offered while stalled: must not be taken.
    op_valid = 1'b1; op_tag_check = 1'b1; ptagcompare = 1'b0;
    step();
    op_valid = 1'b0; op_tag_check = 1'b0; ptagcompare = 1'b1;
    n_cmp++;
    if (check_pass !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL pass_idle got pass/ready/busy=%b%b%b want=010", check_pass, op_ready, busy);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || trap_count !== 2'd0) begin
      n_err++; $display("FAIL pass_no_accept_stalled got busy=%b cnt=%0d want 0/0", busy, trap_count);
    end
  endtask

  task automatic test_fail();
    issue(1'b1, 1'b0, 4'h8, 4'h0, 32'h0000_1A40);
    n_cmp++;
    if (trap_req !== 1'b0 || check_pass !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL fail_eval got req/pass/busy=%b%b%b want=001", trap_req, check_pass, busy);
    end
    step();
    n_cmp++;
    if (trap_req !== 1'b1) begin
      n_err++; $display("FAIL fail_trap_req got=%b want=1", trap_req);
    end
    n_cmp++;
    if (trap_pc !== 32'h0000_1A40 || trap_tags !== 8'h80) begin
      n_err++; $display("FAIL fail_trap_info got=%h/%h want=00001a40/80", trap_pc, trap_tags);
    end
    n_cmp++;
    if (trap_count !== 2'd1) begin
      n_err++; $display("FAIL fail_trap_count got=%0d want=1", trap_count);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (trap_req !== 1'b1 || op_ready !== 1'b0) begin
        n_err++; $display("FAIL fail_hold cyc=%0d got req/ready=%b%b want=10", i, trap_req, op_ready);
      end
    end
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    n_cmp++;
    if (trap_req !== 1'b0 || op_ready !== 1'b0) begin
      n_err++; $display("FAIL fail_recover got req/ready=%b%b want=00", trap_req, op_ready);
    end
    step();
    n_cmp++;
    if (op_ready !== 1'b1 || trap_pc !== 32'h0000_1A40 || trap_tags !== 8'h80) begin
      n_err++;
      $display("FAIL fail_idle got ready=%b pc=%h tags=%h want 1/00001a40/80", op_ready, trap_pc, trap_tags);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1; op_tag_check = 1'b0; ptagcompare = 1'(i % 2);
      tag_a = 4'(i); tag_b = 4'hF; op_pc = 32'h2000 + 32'(i);
      step();
      n_cmp++;
      if (op_ready !== 1'b1 || check_pass !== 1'b0 || trap_req !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL untagged i=%0d got ready/pass/req/busy=%b%b%b%b want=1000",
                 i, op_ready, check_pass, trap_req, busy);
      end
    end
    op_valid = 1'b0; ptagcompare = 1'b1;
    n_cmp++;
    if (trap_count !== 2'd1 || trap_pc !== 32'h0000_1A40) begin
      n_err++; $display("FAIL untagged_state got cnt=%0d pc=%h want 1/00001a40", trap_count, trap_pc);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      issue(1'b1, 1'b0, 4'(i), 4'(15 - i), 32'h3000 + 32'(i * 4));
      // Acknowledge presented before the trap is raised must not count.
      trap_ack = 1'b1;
      step();
      n_cmp++;
      if (trap_req !== 1'b1 || trap_count !== exp_cnt) begin
        n_err++;
        $display("FAIL sat i=%0d got req=%b cnt=%0d want 1/%0d", i, trap_req, trap_count, exp_cnt);
      end
      trap_ack = 1'b0;
      step();
      n_cmp++;
      if (trap_req !== 1'b1 || trap_tags !== {4'(i), 4'(15 - i)}) begin
        n_err++;
        $display("FAIL sat_early_ack i=%0d got req=%b tags=%h", i, trap_req, trap_tags);
      end
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    issue(1'b1, 1'b0, 4'hA, 4'h5, 32'h0000_4444);
    step();
    n_cmp++;
    if (trap_req !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre got req=%b want=1", trap_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (trap_req !== 1'b0 || trap_count !== 2'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async got req=%b cnt=%0d busy=%b want 0/0/0", trap_req, trap_count, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (op_ready !== 1'b1 || trap_count !== 2'd0 || trap_req !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_post got ready=%b cnt=%0d req=%b want 1/0/0", op_ready, trap_count, trap_req);
    end
  endtask

`ifdef TAG_TRAP_MASK_EN
  task automatic test_mask();
    do_reset();
    trap_enable = 1'b0;
    issue(1'b1, 1'b0, 4'hC, 4'h3, 32'h0000_5550);
    step();
    n_cmp++;
    if (trap_req !== 1'b0 || check_pass !== 1'b0 || op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mask got req/pass/ready=%b%b%b want=001", trap_req, check_pass, op_ready);
    end
    n_cmp++;
    if (trap_count !== 2'd1 || trap_pc !== 32'h0000_5550 || trap_tags !== 8'hC3) begin
      n_err++;
      $display("FAIL mask_capture got cnt=%0d pc=%h tags=%h want 1/00005550/c3",
               trap_count, trap_pc, trap_tags);
    end
    step();
    n_cmp++;
    if (trap_req !== 1'b0) begin
      n_err++; $display("FAIL mask_later got req=%b want=0", trap_req);
    end
    trap_enable = 1'b1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    op_valid = 1'b0;
    op_tag_check = 1'b0;
    ptagcompare = 1'b1;
    tag_a = 4'h0;
    tag_b = 4'h0;
    op_pc = '0;
    trap_ack = 1'b0;
    trap_enable = 1'b1;
    test_reset();
    test_pass();
    test_fail();
    test_back_to_back();
    test_saturation();
    test_reset_mid_trap();
`ifdef TAG_TRAP_MASK_EN
    test_mask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tag_trap_sequencer.md
Name: tag_trap_sequencer

Overview:
Downstream consumer of the combinational tag-compare PLA output `ptagcompare`, which is computed from operand tags busA[31:28] and busB[31:28]. It registers the compare result for operations that request a tag check, and stalls the operand stage while it evaluates. On a failed check it raises a held trap request, with captured PC and tags, to the trap handler; it keeps a saturating trap counter.

Parameters:
PC_W, 32, width of captured program counter
CNT_W, 8, width of trap counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  operand stage presents an operation
op_tag_check  input  1  operation requires a tag check
ptagcompare  input  1  PLA result; 1 = tags acceptable, 0 = tag trap
tag_a  input  4  busA[31:28] of the current operation
tag_b  input  4  busB[31:28] of the current operation
op_pc  input  PC_W  PC of the current operation
op_ready  output  1  block can accept an operation this cycle
check_pass  output  1  one-cycle pulse: checked operation passed
trap_req  output  1  trap request, held until acknowledged
trap_ack  input  1  trap handler acknowledge
trap_pc  output  PC_W  PC of the trapping operation
trap_tags  output  8  {tag_a, tag_b} of the trapping operation
trap_count  output  CNT_W  number of traps taken, saturating
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, EVAL, TRAP, RECOVER. Reset state is IDLE.
- Reset values: check_pass=0, trap_req=0, trap_pc=0, trap_tags=0, trap_count=0, busy=0. op_ready=1, because it decodes IDLE.
- op_ready = (state==IDLE), combinational from the state register. Accept = op_valid & op_ready.
- IDLE, accept with op_tag_check=0: operation passes through. No capture, stay IDLE, no pulse.
- IDLE, accept with op_tag_check=1: on the same edge, capture ptagcompare, tag_a, tag_b and op_pc, then go to EVAL.
- EVAL with captured compare=1: check_pass=1 for this cycle, then IDLE. The next operation is accepted 2 cycles after the previous accept.
- EVAL with captured compare=0: go to TRAP. On this edge load trap_pc/trap_tags from the captured values and increment trap_count. trap_count holds at all-ones rather than wrapping.
- TRAP: trap_req=1 (registered), with trap_pc/trap_tags stable. When trap_ack=1 is sampled, go to RECOVER; trap_req is 0 from the following cycle.
- RECOVER: one cycle with op_ready=0, then IDLE. trap_pc/trap_tags keep their last values until the next trap.
- trap_ack in IDLE, EVAL or RECOVER is ignored.
- trap_ack asserted on the cycle TRAP is entered is ignored. Only trap_ack sampled while already in TRAP counts.
- op_valid while op_ready=0 is not accepted; the upstream stage holds its operation.
- Asynchronous reset at any point, including mid-TRAP: trap_req drops immediately, the counter clears, state returns to IDLE.
- Minimum trap sequence: accept N, EVAL N+1, trap_req high N+2 … ack at M, RECOVER M+1, IDLE M+2.

Optional Feature:
TAG_TRAP_MASK_EN
- With the macro defined: adds input port trap_enable (1 bit).
  - A failed check in EVAL while trap_enable=0 still increments trap_count and loads trap_pc/trap_tags.
  - It goes directly to IDLE with no trap_req and no check_pass.
  - trap_enable is sampled in EVAL only.
- Without the macro: no port; every failed check enters TRAP.

Test Plan:
- Reset: hold rst_n=0 3 cycles -> op_ready=1, trap_req=0, trap_count=0, busy=0.
- Pass: accept with op_tag_check=1, tag_a=4'h0, tag_b=4'h0, ptagcompare=1 -> check_pass=1 exactly 1 cycle later, op_ready=1 2 cycles after accept, trap_count=0.
- Fail: accept with tag_a=4'h8, tag_b=4'h0, ptagcompare=0, op_pc=32'h0000_1A40 -> trap_req=1 2 cycles after accept, trap_pc=32'h0000_1A40, trap_tags=8'h80, trap_count=1. Hold trap_ack=0 for 10 cycles -> trap_req stays 1. Pulse trap_ack -> trap_req=0 next cycle, op_ready=1 one cycle after that.
- Untagged back-to-back: 5 consecutive accepts with op_tag_check=0 -> op_ready stays 1, no check_pass, no trap.
- Saturation with CNT_W=2: 5 failed checks, each acked -> trap_count reads 1,2,3,3,3.
- Reset mid-trap: rst_n=0 while trap_req=1 -> trap_req=0 asynchronously. After release, state is IDLE and trap_count=0. With TAG_TRAP_MASK_EN and trap_enable=0, a failed check -> trap_count=1, trap_req never asserts.
